// File: rtl/uart_pkg.sv
// Shared types and constants for the wishbone-fed UART transmitter.
// UART_TX_PARITY_EN adds a parity bit between the data bits and the stop bit.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      PARITY
   } state_t;

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_DIV  = 2'd1;
   localparam logic [1:0] REG_CTRL = 2'd2;

   localparam int CTRL_ENABLE  = 0;
   localparam int CTRL_FLUSH   = 1;
   localparam int CTRL_CLR_OVF = 2;
   localparam int CTRL_ODD_PAR = 3;

   localparam int DIV_MIN = 4;

   // Bit times shorter than DIV_MIN cycles are raised to DIV_MIN.
   function automatic logic [31:0] clamp_div(input logic [31:0] d);
      return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is accepted when a pop
// happens in the same cycle. Output is the current head (no fall-through).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [LVL_W-1:0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LVL_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == LVL_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_level   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && (!o_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty;

   // NOTE: storage has no reset; only pointers and count define valid contents.
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + LVL_W'(1);
            2'b01:   r_count <= r_count - LVL_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_uart_tx.sv
// UART transmitter for one harness project slot: wishbone writes feed a FIFO,
// bytes go out 8N1 on tx. Optional macro UART_TX_PARITY_EN adds a parity bit.
module wb_uart_tx
   import uart_pkg::*;
#(
   parameter int               DEPTH     = 8,
   parameter int               DIV_W     = 16,
   parameter logic [DIV_W-1:0] DIV_RESET = 16'd868
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wb_update,
   input  logic [1:0]  wb_reg,
   input  logic [31:0] wb_data,
   output logic        tx,
   output logic        busy,
   output logic [31:0] status
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   state_t           r_state;
   state_t           w_state_next;
   logic [7:0]       r_shift;
   logic [2:0]       r_bit_cnt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_active_div;
   logic [DIV_W-1:0] r_baud_cnt;
   logic             r_tx;
   logic             r_enable;
   logic             r_overflow;
`ifdef UART_TX_PARITY_EN
   logic             r_odd_par;
   logic             r_parity;
`endif

   logic             w_push;
   logic             w_pop;
   logic             w_flush;
   logic             w_wr_ctrl;
   logic             w_full;
   logic             w_empty;
   logic [LVL_W-1:0] w_level;
   logic [7:0]       w_level8;
   logic [7:0]       w_head;
   logic             w_bit_end;
   logic             w_start_ok;
   logic             w_shift_adv;
   logic             w_tx_next;
   logic             w_unused;

   assign w_push     = wb_update && (wb_reg == REG_DATA);
   assign w_wr_ctrl  = wb_update && (wb_reg == REG_CTRL);
   assign w_flush    = w_wr_ctrl && wb_data[CTRL_FLUSH];
   assign w_start_ok = r_enable && !w_empty;
   assign w_bit_end  = (r_baud_cnt == r_active_div - DIV_W'(1));
   assign w_level8   = 8'(w_level);
   assign w_unused   = ^wb_data;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (wb_data[7:0]),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_shift_adv  = 1'b0;
      w_tx_next    = r_tx;
      case (r_state)
         IDLE: if (w_start_ok) begin
            w_state_next = START;
            w_pop        = 1'b1;
            w_tx_next    = 1'b0;
         end
         START: if (w_bit_end) begin
            w_state_next = DATA;
            w_shift_adv  = 1'b1;
            w_tx_next    = r_shift[0];
         end
         DATA: if (w_bit_end) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               w_state_next = PARITY;
               w_tx_next    = r_parity;
`else
               w_state_next = STOP;
               w_tx_next    = 1'b1;
`endif
            end else begin
               w_shift_adv = 1'b1;
               w_tx_next   = r_shift[0];
            end
         end
         PARITY: if (w_bit_end) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
         end
         STOP: if (w_bit_end) begin
            // Back-to-back frames start straight from the end of the stop bit.
            if (w_start_ok) begin
               w_state_next = START;
               w_pop        = 1'b1;
               w_tx_next    = 1'b0;
            end else begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx         <= 1'b1;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_baud_cnt   <= '0;
         r_active_div <= DIV_RESET;
`ifdef UART_TX_PARITY_EN
         r_parity     <= 1'b0;
`endif
      end else begin
         r_tx <= w_tx_next;
         if (w_pop) begin
            r_shift      <= w_head;
            r_active_div <= r_div;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= (^w_head) ^ r_odd_par;
`endif
         end else if (r_state != IDLE) begin
            r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + DIV_W'(1);
            if (w_shift_adv)
               r_shift <= {1'b0, r_shift[7:1]};
            if ((r_state == DATA) && w_bit_end)
               r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div      <= DIV_RESET;
         r_enable   <= 1'b0;
         r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_odd_par  <= 1'b0;
`endif
      end else begin
         if (wb_update && (wb_reg == REG_DIV))
            r_div <= DIV_W'(clamp_div(32'(wb_data[DIV_W-1:0])));
         if (w_wr_ctrl) begin
            r_enable  <= wb_data[CTRL_ENABLE];
`ifdef UART_TX_PARITY_EN
            r_odd_par <= wb_data[CTRL_ODD_PAR];
`endif
         end
         if (w_push && w_full && !w_pop)
            r_overflow <= 1'b1;
         else if (w_wr_ctrl && wb_data[CTRL_CLR_OVF])
            r_overflow <= 1'b0;
      end
   end

   assign tx     = r_tx;
   assign busy   = (r_state != IDLE) || (r_enable && !w_empty);
   assign status = {r_overflow, 15'b0, w_full, w_empty, 6'b0, w_level8};

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed self-checking bench for wb_uart_tx (honours UART_TX_PARITY_EN).
module tb_wb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wb_update = 1'b0;
   logic [1:0]  wb_reg = 2'd0;
   logic [31:0] wb_data = '0;
   logic        tx;
   logic        busy;
   logic [31:0] status;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   wb_uart_tx dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wb_update (wb_update),
      .wb_reg    (wb_reg),
      .wb_data   (wb_data),
      .tx        (tx),
      .busy      (busy),
      .status    (status)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
      wb_update = 1'b1;
      wb_reg    = r;
      wb_data   = d;
      tick();
      wb_update = 1'b0;
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Checks tx each cycle of one frame starting at the current sample point;
   // optionally issues one register write at cycle wr_at.
   task automatic check_frame(input string tag, input logic [7:0] b, input int div,
                              input int wr_at, input logic [1:0] wr_reg, input logic [31:0] wr_data);
      for (int i = 0; i < NBITS * div; i++) begin
         check($sformatf("%s_c%0d", tag, i), 32'(tx), 32'(exp_bit(b, i / div)));
         if (i == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
         if (i == wr_at) begin
            wb_update = 1'b1;
            wb_reg    = wr_reg;
            wb_data   = wr_data;
         end
         tick();
         wb_update = 1'b0;
      end
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_status", status, 32'h0000_4000);
      reset_n = 1'b1;
      tick();

      // Single frame 0xA5 at div=4
      wb_write(2'd1, 32'd4);
      wb_write(2'd2, 32'h1);
      wb_write(2'd0, 32'hA5);
      check("a5_pop_cycle_tx", 32'(tx), 32'd1);
      check("a5_level", status, 32'h0000_0001);
      tick();
      check_frame("a5", 8'hA5, 4, -1, 2'd0, 32'h0);
      check("a5_idle_tx", 32'(tx), 32'd1);
      check("a5_idle_busy", 32'(busy), 32'd0);

      // Back-to-back 0x00 then 0xFF, no gap between frames
      wb_write(2'd0, 32'h00);
      wb_write(2'd0, 32'hFF);
      check_frame("b2b0", 8'h00, 4, -1, 2'd0, 32'h0);
      check_frame("b2b1", 8'hFF, 4, -1, 2'd0, 32'h0);
      check("b2b_busy", 32'(busy), 32'd0);
      check("b2b_status", status, 32'h0000_4000);

      // Overflow with enable off, then sticky clear and flush
      wb_write(2'd2, 32'h0);
      for (int i = 0; i < 9; i++) wb_write(2'd0, 32'h10 + 32'(i));
      check("ovf_status", status, 32'h8000_8008);
      check("ovf_busy", 32'(busy), 32'd0);
      wb_write(2'd2, 32'h4);
      check("ovf_clr_status", status, 32'h0000_8008);
      wb_write(2'd2, 32'h2);
      check("flush_status", status, 32'h0000_4000);
      wb_write(2'd3, 32'hFFFF_FFFF);
      check("reg3_status", status, 32'h0000_4000);

      // Divider clamp and mid-frame divider change
      wb_write(2'd1, 32'd2);
      wb_write(2'd2, 32'h1);
      wb_write(2'd0, 32'h3C);
      wb_write(2'd0, 32'hC3);
      check_frame("div4", 8'h3C, 4, 5, 2'd1, 32'd8);
      check_frame("div8", 8'hC3, 8, -1, 2'd0, 32'h0);
      check("div_status", status, 32'h0000_4000);

      // Flush during the first of three queued frames
      wb_write(2'd1, 32'd4);
      wb_write(2'd2, 32'h0);
      wb_write(2'd0, 32'h11);
      wb_write(2'd0, 32'h22);
      wb_write(2'd0, 32'h33);
      check("fl_level", status, 32'h0000_0003);
      wb_write(2'd2, 32'h1);
      tick();
      check("fl_level_popped", status, 32'h0000_0002);
      check_frame("fl", 8'h11, 4, 6, 2'd2, 32'h3);
      check("fl_status", status, 32'h0000_4000);
      check("fl_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fl_idle_tx%0d", i), 32'(tx), 32'd1);
         tick();
      end

      // Asynchronous reset mid-DATA
      wb_write(2'd0, 32'h5A);
      wb_write(2'd0, 32'h77);
      repeat (13) tick();
      check("mid_tx", 32'(tx), 32'd0);
      check("mid_status", status, 32'h0000_0001);
      reset_n = 1'b0;
      #2;
      check("arst_tx", 32'(tx), 32'd1);
      check("arst_status", status, 32'h0000_4000);
      check("arst_busy", 32'(busy), 32'd0);
      #2;
      reset_n = 1'b1;
      tick();

      // Divider returns to its reset value (868)
      wb_write(2'd2, 32'h1);
      wb_write(2'd0, 32'h01);
      tick();
      check("dr_start", 32'(tx), 32'd0);
      repeat (867) tick();
      check("dr_last_start", 32'(tx), 32'd0);
      tick();
      check("dr_bit0", 32'(tx), 32'd1);

`ifdef UART_TX_PARITY_EN
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
      wb_write(2'd1, 32'd4);
      wb_write(2'd2, 32'h1);
      wb_write(2'd0, 32'h07);
      tick();
      check_frame("par07", 8'h07, 4, -1, 2'd0, 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
